// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM access scheduler: command opcodes and FSM states.
// SDRAM_SCHED_REFRESH_EN adds the REFRESH state.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_WRITE   = 2'd1,
        OP_READ    = 2'd2,
        OP_REFRESH = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
`ifdef SDRAM_SCHED_REFRESH_EN
        , S_REFRESH
`endif
    } state_t;

endpackage

// File: rtl/sdram_sched_rsp_collector.sv
// In-order read response collector: response pointer, per-channel result
// registers and the all-responses-received flag for the current frame.
module sdram_sched_rsp_collector
    import sdram_sched_pkg::*;
#(
    parameter int NUM = 16,
    parameter int DW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic                     rsp_valid_i,
    input  logic [DW-1:0]            rsp_data_i,
    output logic [NUM-1:0][DW-1:0]   readdata_o,
    output logic                     all_done_o
);

    localparam int CW = $clog2(NUM);
    localparam logic [CW:0] RP_FULL = (CW+1)'(NUM);
    localparam logic [CW:0] RP_LAST = (CW+1)'(NUM - 1);
    localparam logic [CW:0] RP_ONE  = (CW+1)'(1);

    logic [CW:0]               rp_q, rp_d;
    logic [NUM-1:0][DW-1:0]    data_q;
    logic                      take;

    // Responses outside a frame, or beyond NUM, never touch the results.
    always_comb begin
        take       = enable_i && rsp_valid_i && (rp_q != RP_FULL);
        rp_d       = rp_q;
        if (clear_i) begin
            rp_d = '0;
        end else if (take) begin
            rp_d = rp_q + RP_ONE;
        end
        all_done_o = (rp_q == RP_FULL) || (take && (rp_q == RP_LAST));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rp_q   <= '0;
            data_q <= '0;
        end else begin
            rp_q <= rp_d;
            if (take) begin
                data_q[rp_q[CW-1:0]] <= rsp_data_i;
            end
        end
    end

    assign readdata_o = data_q;

endmodule

// File: rtl/sdram_access_scheduler.sv
// Per-frame SDRAM access sequencer: per channel an optional WRITE then a READ,
// issued over valid/ready, with in-order responses collected per channel.
// Optional feature macro: SDRAM_SCHED_REFRESH_EN (one REFRESH command per frame).
module sdram_access_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int NUM = 16,
    parameter int AW  = 22,
    parameter int DW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [NUM-1:0][DW-1:0]   writedata_i,
    input  logic [NUM-1:0][AW-1:0]   write_address_i,
    input  logic [NUM-1:0]           write_enable_i,
    input  logic [NUM-1:0][AW-1:0]   read_address_i,
    output logic [NUM-1:0][DW-1:0]   readdata_o,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     overrun_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [1:0]               cmd_op_o,
    output logic [AW-1:0]            cmd_addr_o,
    output logic [DW-1:0]            cmd_wdata_o,
    input  logic                     rsp_valid_i,
    input  logic [DW-1:0]            rsp_data_i
);

    localparam int CW = $clog2(NUM);

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d, ch_inc;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
    logic            valid_q, valid_d;
    cmd_op_t         op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            frame_start, accept, all_done;

    assign frame_start = (state_q == S_IDLE) && start_i;
    assign accept      = valid_q && cmd_ready_i;
    assign ch_inc      = ch_q + CW'(1);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        ovr_d   = start_i && (state_q != S_IDLE);
        valid_d = valid_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ch_d    = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = write_enable_i[0] ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (accept) begin
                    if (ch_q == CW'(NUM - 1)) begin
`ifdef SDRAM_SCHED_REFRESH_EN
                        state_d = S_REFRESH;
`else
                        state_d = S_DRAIN;
`endif
                    end else begin
                        ch_d    = ch_inc;
                        state_d = write_enable_i[ch_inc] ? S_WRITE : S_READ;
                    end
                end
            end
`ifdef SDRAM_SCHED_REFRESH_EN
            S_REFRESH: begin
                if (accept) begin
                    state_d = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                if (all_done) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Command registers reload only when a new command begins, so a
        // stalled command stays bit-for-bit stable until accepted.
        if (frame_start || accept) begin
            valid_d = 1'b0;
            op_d    = OP_NOP;
            addr_d  = '0;
            wdata_d = '0;
            case (state_d)
                S_WRITE: begin
                    valid_d = 1'b1;
                    op_d    = OP_WRITE;
                    addr_d  = write_address_i[ch_d];
                    wdata_d = writedata_i[ch_d];
                end
                S_READ: begin
                    valid_d = 1'b1;
                    op_d    = OP_READ;
                    addr_d  = read_address_i[ch_d];
                end
`ifdef SDRAM_SCHED_REFRESH_EN
                S_REFRESH: begin
                    valid_d = 1'b1;
                    op_d    = OP_REFRESH;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    sdram_sched_rsp_collector #(
        .NUM (NUM),
        .DW  (DW)
    ) u_rsp (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (frame_start),
        .enable_i    (busy_q),
        .rsp_valid_i (rsp_valid_i),
        .rsp_data_i  (rsp_data_i),
        .readdata_o  (readdata_o),
        .all_done_o  (all_done)
    );

    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign overrun_o   = ovr_q;
    assign cmd_valid_o = valid_q;
    assign cmd_op_o    = op_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_wdata_o = wdata_q;

endmodule

// File: tb/tb_sdram_access_scheduler.sv
// Directed bench for sdram_access_scheduler (NUM=4) with a fixed-latency (3)
// in-order responder; honours SDRAM_SCHED_REFRESH_EN in its expectations.
module tb_sdram_access_scheduler;

    logic              clk = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              start_i = 1'b0;
    logic [3:0][15:0]  wd = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    logic [3:0][7:0]   wa = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic [3:0][7:0]   ra = {8'h84, 8'h63, 8'h42, 8'h21};
    logic [3:0]        write_enable_i = 4'hF;
    logic [3:0][15:0]  readdata_o;
    logic              ready_o, busy_o, overrun_o;
    logic              cmd_valid_o;
    logic              cmd_ready_i = 1'b0;
    logic [1:0]        cmd_op_o;
    logic [7:0]        cmd_addr_o;
    logic [15:0]       cmd_wdata_o;
    logic              rsp_valid_i = 1'b0;
    logic [15:0]       rsp_data_i = '0;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic              rdy_rand = 1'b0;
    logic [7:0]        rsp_tag  = 8'h00;
    logic [25:0]       log_q[$];
    int                acc_cyc[$];
    int                ovr_cnt  = 0;
    int                ovr_cyc  = -1;

    sdram_access_scheduler #(
        .NUM (4),
        .AW  (8),
        .DW  (16)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .writedata_i     (wd),
        .write_address_i (wa),
        .write_enable_i  (write_enable_i),
        .read_address_i  (ra),
        .readdata_o      (readdata_o),
        .ready_o         (ready_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o),
        .cmd_valid_o     (cmd_valid_o),
        .cmd_ready_i     (cmd_ready_i),
        .cmd_op_o        (cmd_op_o),
        .cmd_addr_o      (cmd_addr_o),
        .cmd_wdata_o     (cmd_wdata_o),
        .rsp_valid_i     (rsp_valid_i),
        .rsp_data_i      (rsp_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] cw_w(input int k);
        return {2'd1, wa[k], wd[k]};
    endfunction

    function automatic logic [25:0] cw_r(input int k);
        return {2'd2, ra[k], 16'h0000};
    endfunction

    // Ready driver, command logger, stall-stability monitor and L=3 responder.
    initial begin
        logic        pv [3];
        logic [15:0] pd [3];
        logic        prev_stall;
        logic [25:0] prev_cmd;
        prev_stall = 1'b0;
        prev_cmd   = '0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (prev_stall)
                check_eq("stall_hold", {37'd0, cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_wdata_o},
                         {37'd0, 1'b1, prev_cmd});
            cmd_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp_valid_i = pv[2];
            rsp_data_i  = pd[2];
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = 1'b0;  pd[0] = '0;
            if (cmd_valid_o && cmd_ready_i) begin
                log_q.push_back({cmd_op_o, cmd_addr_o, cmd_wdata_o});
                acc_cyc.push_back(cyc + 1);
                if (cmd_op_o == 2'd2) begin
                    pv[0] = 1'b1;
                    pd[0] = {rsp_tag, cmd_addr_o};
                end
            end
            if (overrun_o) begin
                ovr_cnt++;
                ovr_cyc = cyc;
            end
            prev_stall = cmd_valid_o && !cmd_ready_i;
            prev_cmd   = {cmd_op_o, cmd_addr_o, cmd_wdata_o};
        end
    end

    task automatic check_log(input string nm, input logic [25:0] e[$]);
`ifdef SDRAM_SCHED_REFRESH_EN
        e.push_back({2'd3, 8'h00, 16'h0000});
`endif
        check_eq({nm, "_count"}, 64'(log_q.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            check_eq($sformatf("%s_cmd%0d", nm, i), 64'(log_q[i]), 64'(e[i]));
    endtask

    task automatic run_frame(input logic [3:0] we, input logic [7:0] tag, input int mid,
                             output int t0, output int t_rdy, output logic [2:0] first);
        write_enable_i = we;
        rsp_tag = tag;
        log_q.delete();
        acc_cyc.delete();
        ovr_cnt = 0;
        ovr_cyc = -1;
        @(negedge clk);
        start_i = 1'b1;
        t0    = cyc + 1;
        t_rdy = -1;
        first = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            start_i = (mid > 0) && (cyc + 1 == t0 + mid);
            if (n == 0) first = {busy_o, ready_o, cmd_valid_o};
            if (ready_o) begin
                t_rdy = cyc;
                break;
            end
        end
        start_i = 1'b0;
        if (t_rdy < 0) check_eq("ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          t0, tr, extra;
        logic [2:0]  first;
        logic [25:0] e[$];
`ifdef SDRAM_SCHED_REFRESH_EN
        extra = 1;
`else
        extra = 0;
`endif

        #1;
        check_eq("rst_cmd", {38'd0, cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_wdata_o}, 64'd0);
        check_eq("rst_flags", {61'd0, ready_o, busy_o, overrun_o}, 64'd0);
        check_eq("rst_readdata", readdata_o, 64'd0);
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // All channels write-enabled, ready tied high.
        run_frame(4'hF, 8'hD0, 0, t0, tr, first);
        check_eq("t1_first", 64'(first), 64'(3'b101));
        e = {cw_w(0), cw_r(0), cw_w(1), cw_r(1), cw_w(2), cw_r(2), cw_w(3), cw_r(3)};
        check_log("t1", e);
        if (acc_cyc.size() > 0) begin
            check_eq("t1_first_acc", 64'(acc_cyc[0] - t0), 64'd1);
            check_eq("t1_last_acc", 64'(acc_cyc[$] - t0), 64'(8 + extra));
        end
        check_eq("t1_ready_at", 64'(tr - t0), 64'd11);
        check_eq("t1_readdata", readdata_o, 64'hD084_D063_D042_D021);
        check_eq("t1_busy_end", {63'd0, busy_o}, 64'd0);
        check_eq("t1_no_ovr", 64'(ovr_cnt), 64'd0);

        // Sparse writes: channels 1 and 3 skip their write phase.
        run_frame(4'b0101, 8'hE0, 0, t0, tr, first);
        e = {cw_w(0), cw_r(0), cw_r(1), cw_w(2), cw_r(2), cw_r(3)};
        check_log("t2", e);
        if (acc_cyc.size() > 0)
            check_eq("t2_last_acc", 64'(acc_cyc[$] - t0), 64'(6 + extra));
        check_eq("t2_ready_at", 64'(tr - t0), 64'd9);
        check_eq("t2_readdata", readdata_o, 64'hE084_E063_E042_E021);

        // Random backpressure.
        rdy_rand = 1'b1;
        run_frame(4'b1011, 8'hC3, 0, t0, tr, first);
        rdy_rand = 1'b0;
        e = {cw_w(0), cw_r(0), cw_w(1), cw_r(1), cw_r(2), cw_w(3), cw_r(3)};
        check_log("t3", e);
        check_eq("t3_readdata", readdata_o, 64'hC384_C363_C342_C321);

        // Start strobe during a frame.
        run_frame(4'hF, 8'hB7, 3, t0, tr, first);
        e = {cw_w(0), cw_r(0), cw_w(1), cw_r(1), cw_w(2), cw_r(2), cw_w(3), cw_r(3)};
        check_log("t4", e);
        check_eq("t4_ovr_cnt", 64'(ovr_cnt), 64'd1);
        check_eq("t4_ovr_at", 64'(ovr_cyc - t0), 64'd3);
        check_eq("t4_ready_at", 64'(tr - t0), 64'd11);
        check_eq("t4_readdata", readdata_o, 64'hB784_B763_B742_B721);

        // Asynchronous reset after three accepted commands.
        write_enable_i = 4'hF;
        rsp_tag = 8'h99;
        log_q.delete();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #3;
            if (log_q.size() >= 3) break;
        end
        rst_n_i = 1'b0;
        #1;
        check_eq("t5_acc_before_rst", 64'(log_q.size()), 64'd3);
        check_eq("t5_rst_cmd", {38'd0, cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_wdata_o}, 64'd0);
        check_eq("t5_rst_flags", {61'd0, ready_o, busy_o, overrun_o}, 64'd0);
        check_eq("t5_rst_readdata", readdata_o, 64'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t5_idle_rsp_ignored", readdata_o, 64'd0);
        check_eq("t5_idle_flags", {62'd0, busy_o, cmd_valid_o}, 64'd0);

        run_frame(4'hF, 8'h5A, 0, t0, tr, first);
        e = {cw_w(0), cw_r(0), cw_w(1), cw_r(1), cw_w(2), cw_r(2), cw_w(3), cw_r(3)};
        check_log("t5", e);
        check_eq("t5_ready_at", 64'(tr - t0), 64'd11);
        check_eq("t5_readdata", readdata_o, 64'h5A84_5A63_5A42_5A21);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
